// File: rtl/io_timer_pkg.sv
// Shared definitions for io_timer: register byte offsets, CTRL bit positions,
// run-state encoding and a byte-lane merge helper.
package io_timer_pkg;

  localparam logic [3:0] OffCtrl     = 4'd0;
  localparam logic [3:0] OffPrescale = 4'd2;
  localparam logic [3:0] OffReload   = 4'd4;
  localparam logic [3:0] OffCount    = 4'd6;
  localparam logic [3:0] OffCompare  = 4'd8;

  localparam int unsigned CtrlEn         = 0;
  localparam int unsigned CtrlIe         = 1;
  localparam int unsigned CtrlAutoreload = 2;
  localparam int unsigned CtrlFlag       = 3;

  typedef enum logic {
    StStopped,
    StRunning
  } state_e;

  function automatic logic [15:0] byte_merge(input logic [15:0] cur,
                                             input logic        wr_lo,
                                             input logic        wr_hi,
                                             input logic [7:0]  val_lo,
                                             input logic [7:0]  val_hi);
    logic [15:0] res;
    res = cur;
    if (wr_lo) res[7:0] = val_lo;
    if (wr_hi) res[15:8] = val_hi;
    return res;
  endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// Free-running 0..limit counter; tick is high in the cycle the count equals limit.
module io_timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] limit,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!enable || clear || tick) cnt_d = 16'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped countdown timer with prescaler, auto-reload and level interrupt.
// Define IO_TIMER_PWM_EN to add the COMPARE register (+8) and the pwm output.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASEADDR = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  output logic        interrupt
`ifdef IO_TIMER_PWM_EN
  ,
  output logic        pwm
`endif
);

`ifdef IO_TIMER_PWM_EN
  localparam logic [15:0] WinBytes = 16'd10;
`else
  localparam logic [15:0] WinBytes = 16'd8;
`endif

  state_e      state_q, state_d;
  logic        ie_q, ie_d, ar_q, ar_d, flag_q, flag_d;
  logic [15:0] prescale_q, prescale_d, reload_q, reload_d, count_q, count_d;
  logic [15:0] rdata_q, rdata_d;
  logic        irq_q;
  logic        tick, expire, ctrl_wr, pre_clear;
  logic [7:0]  ctrl_val;

  // Per-byte write strobes and data, indexed by window offset.
  logic [15:0]      wr_byte;
  logic [15:0][7:0] wr_val;
  logic [15:0]      woff0, woff1, roff0, roff1;
  logic [15:0][7:0] rview;
  logic [7:0]       rd_lo, rd_hi;
  logic             unused_wr;

  assign woff0 = dwrite_addr - BASEADDR;
  assign woff1 = dwrite_addr + 16'd1 - BASEADDR;

  always_comb begin
    wr_byte = '0;
    wr_val  = '0;
    if (dwrite_en[0] && (woff0 < WinBytes)) begin
      wr_byte[woff0[3:0]] = 1'b1;
      wr_val[woff0[3:0]]  = dwrite_data[7:0];
    end
    if (dwrite_en[1] && (woff1 < WinBytes)) begin
      wr_byte[woff1[3:0]] = 1'b1;
      wr_val[woff1[3:0]]  = dwrite_data[15:8];
    end
  end

  assign unused_wr = ^{wr_byte, wr_val};

  assign ctrl_wr   = wr_byte[OffCtrl];
  assign ctrl_val  = wr_val[OffCtrl];
  assign pre_clear = ctrl_wr || wr_byte[OffPrescale] || wr_byte[OffPrescale+4'd1];
  assign expire    = tick && (count_q == 16'd0);

  io_timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == StRunning),
    .clear  (pre_clear),
    .limit  (prescale_q),
    .tick   (tick)
  );

  // Expiry without auto-reload stops the timer even if EN is rewritten to 1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStopped: if (ctrl_wr && ctrl_val[CtrlEn]) state_d = StRunning;
      StRunning: if ((expire && !ar_q) || (ctrl_wr && !ctrl_val[CtrlEn])) state_d = StStopped;
      default:   state_d = StStopped;
    endcase
  end

  always_comb begin
    ie_d   = ie_q;
    ar_d   = ar_q;
    flag_d = flag_q;
    if (ctrl_wr) begin
      ie_d = ctrl_val[CtrlIe];
      ar_d = ctrl_val[CtrlAutoreload];
      if (ctrl_val[CtrlFlag]) flag_d = 1'b0;
    end
    if (expire) flag_d = 1'b1;
  end

  assign prescale_d = byte_merge(prescale_q, wr_byte[OffPrescale], wr_byte[OffPrescale+4'd1],
                                 wr_val[OffPrescale], wr_val[OffPrescale+4'd1]);
  assign reload_d   = byte_merge(reload_q, wr_byte[OffReload], wr_byte[OffReload+4'd1],
                                 wr_val[OffReload], wr_val[OffReload+4'd1]);

  // A bus write to either COUNT byte suppresses decrement/reload for the whole register.
  always_comb begin
    count_d = count_q;
    if (tick) begin
      if (count_q != 16'd0) count_d = count_q - 16'd1;
      else if (ar_q)        count_d = reload_q;
    end
    if (wr_byte[OffCount] || wr_byte[OffCount+4'd1]) begin
      count_d = byte_merge(count_q, wr_byte[OffCount], wr_byte[OffCount+4'd1],
                           wr_val[OffCount], wr_val[OffCount+4'd1]);
    end
  end

`ifdef IO_TIMER_PWM_EN
  logic [15:0] compare_q, compare_d;
  logic        pwm_q;

  assign compare_d = byte_merge(compare_q, wr_byte[OffCompare], wr_byte[OffCompare+4'd1],
                                wr_val[OffCompare], wr_val[OffCompare+4'd1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare_q <= 16'd0;
      pwm_q     <= 1'b0;
    end else begin
      compare_q <= compare_d;
      pwm_q     <= (state_d == StRunning) && (count_d < compare_d);
    end
  end

  assign pwm = pwm_q;
`endif

  always_comb begin
    rview = '0;
    rview[OffCtrl]              = {4'b0000, flag_q, ar_q, ie_q, state_q == StRunning};
    rview[OffPrescale]          = prescale_q[7:0];
    rview[OffPrescale+4'd1]     = prescale_q[15:8];
    rview[OffReload]            = reload_q[7:0];
    rview[OffReload+4'd1]       = reload_q[15:8];
    rview[OffCount]             = count_q[7:0];
    rview[OffCount+4'd1]        = count_q[15:8];
`ifdef IO_TIMER_PWM_EN
    rview[OffCompare]           = compare_q[7:0];
    rview[OffCompare+4'd1]      = compare_q[15:8];
`endif
  end

  assign roff0   = dread_addr - BASEADDR;
  assign roff1   = dread_addr + 16'd1 - BASEADDR;
  assign rd_lo   = (roff0 < WinBytes) ? rview[roff0[3:0]] : 8'h00;
  assign rd_hi   = (roff1 < WinBytes) ? rview[roff1[3:0]] : 8'h00;
  assign rdata_d = {rd_hi, rd_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StStopped;
      ie_q       <= 1'b0;
      ar_q       <= 1'b0;
      flag_q     <= 1'b0;
      prescale_q <= 16'd0;
      reload_q   <= 16'd0;
      count_q    <= 16'd0;
      rdata_q    <= 16'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      ar_q       <= ar_d;
      flag_q     <= flag_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      irq_q      <= flag_d && ie_d;
    end
  end

  assign dread_data = rdata_q;
  assign interrupt  = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios plus randomized bus traffic
// checked against a cycle-level behavioural model. Honours IO_TIMER_PWM_EN.
module tb_io_timer;

  localparam logic [15:0] BASE = 16'h0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dread_addr = '0, dwrite_addr = '0, dwrite_data = '0;
  logic [1:0]  dwrite_en = '0;
  logic [15:0] dread_data;
  logic        interrupt;
`ifdef IO_TIMER_PWM_EN
  logic        pwm;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_timer #(.BASEADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .dread_addr  (dread_addr),
    .dread_data  (dread_data),
    .dwrite_addr (dwrite_addr),
    .dwrite_data (dwrite_data),
    .dwrite_en   (dwrite_en),
    .interrupt   (interrupt)
`ifdef IO_TIMER_PWM_EN
    ,
    .pwm         (pwm)
`endif
  );

  // Behavioural model: registers as plain values, prescaler as elapsed-cycle phase.
  logic        m_en, m_ie, m_ar, m_flag;
  logic [15:0] m_pre, m_rel, m_cnt, m_cmp, m_phase, m_rdata;
  logic        m_irq, m_pwm;

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_ar = 0; m_flag = 0;
    m_pre = 0; m_rel = 0; m_cnt = 0; m_cmp = 0; m_phase = 0;
    m_rdata = 0; m_irq = 0; m_pwm = 0;
  endtask

  function automatic logic [7:0] m_byte(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    case (off)
      16'd0: return {4'b0000, m_flag, m_ar, m_ie, m_en};
      16'd2: return m_pre[7:0];
      16'd3: return m_pre[15:8];
      16'd4: return m_rel[7:0];
      16'd5: return m_rel[15:8];
      16'd6: return m_cnt[7:0];
      16'd7: return m_cnt[15:8];
`ifdef IO_TIMER_PWM_EN
      16'd8: return m_cmp[7:0];
      16'd9: return m_cmp[15:8];
`endif
      default: return 8'h00;
    endcase
  endfunction

  // Drive one bus cycle, advance the model across the edge, return 1ns after it.
  task automatic step(input logic [15:0] ra, input logic [15:0] wa, input logic [15:0] wd,
                      input logic [1:0] we);
    logic        tick, expired, clr, cnt_wr;
    logic        n_en, n_ie, n_ar, n_flag;
    logic [15:0] n_pre, n_rel, n_cnt, n_cmp, n_phase, cnt_new, off, n_rdata;
    logic [7:0]  b;
    dread_addr = ra; dwrite_addr = wa; dwrite_data = wd; dwrite_en = we;
    tick    = m_en && (m_phase == m_pre);
    expired = tick && (m_cnt == 16'd0);
    n_en = m_en; n_ie = m_ie; n_ar = m_ar; n_flag = m_flag;
    n_pre = m_pre; n_rel = m_rel; n_cnt = m_cnt; n_cmp = m_cmp;
    n_rdata = {m_byte(ra + 16'd1), m_byte(ra)};
    if (tick) begin
      if (m_cnt != 0) n_cnt = m_cnt - 16'd1;
      else begin
        n_flag = 1;
        if (m_ar) n_cnt = m_rel;
        else      n_en = 0;
      end
    end
    n_phase = (m_en && !tick) ? m_phase + 16'd1 : 16'd0;
    clr = 0; cnt_wr = 0; cnt_new = m_cnt;
    for (int l = 0; l < 2; l++) begin
      if (we[l]) begin
        off = wa + 16'(l) - BASE;
        b   = wd[8*l +: 8];
        case (off)
          16'd0: begin
            n_ie = b[1]; n_ar = b[2]; clr = 1;
            if (b[3] && !expired) n_flag = 0;
            if (!(expired && !m_ar)) n_en = b[0];
          end
          16'd2: begin n_pre[7:0] = b; clr = 1; end
          16'd3: begin n_pre[15:8] = b; clr = 1; end
          16'd4: n_rel[7:0] = b;
          16'd5: n_rel[15:8] = b;
          16'd6: begin cnt_new[7:0] = b; cnt_wr = 1; end
          16'd7: begin cnt_new[15:8] = b; cnt_wr = 1; end
`ifdef IO_TIMER_PWM_EN
          16'd8: n_cmp[7:0] = b;
          16'd9: n_cmp[15:8] = b;
`endif
          default: ;
        endcase
      end
    end
    if (cnt_wr) n_cnt = cnt_new;
    if (clr) n_phase = 0;
    @(posedge clk);
    #1;
    m_en = n_en; m_ie = n_ie; m_ar = n_ar; m_flag = n_flag;
    m_pre = n_pre; m_rel = n_rel; m_cnt = n_cnt; m_cmp = n_cmp; m_phase = n_phase;
    m_rdata = n_rdata;
    m_irq = n_flag && n_ie;
    m_pwm = n_en && (n_cnt < n_cmp);
    dwrite_en = 2'b00;
  endtask

  task automatic do_reset();
    dwrite_en = 2'b00;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if (dread_data !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h want 0000", dread_data);
    end
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", interrupt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(BASE + 16'(2 * i), 16'h0, 16'h0, 2'b00);
      checks++;
      if (dread_data !== 16'h0000) begin
        errors++; $display("FAIL reset_reg%0d: got %h want 0000", i, dread_data);
      end
    end
  endtask

  task automatic test_autoreload();
    do_reset();
    step(0, BASE + 16'd2, 16'h0003, 2'b11);
    step(0, BASE + 16'd4, 16'h0009, 2'b11);
    step(0, BASE + 16'd6, 16'h0002, 2'b11);
    step(0, BASE, 16'h0005, 2'b01);
    for (int k = 1; k <= 12; k++) begin
      step(BASE, 16'h0, 16'h0, 2'b00);
      checks++;
      if (dread_data !== 16'h0005) begin
        errors++; $display("FAIL autoreload_pre%0d: got %h want 0005", k, dread_data);
      end
    end
    step(BASE, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h000D) begin
      errors++; $display("FAIL autoreload_flag: got %h want 000d", dread_data);
    end
    step(BASE + 16'd6, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h0009) begin
      errors++; $display("FAIL autoreload_count: got %h want 0009", dread_data);
    end
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL autoreload_noirq: got %b want 0", interrupt);
    end
  endtask

  task automatic test_irq();
    do_reset();
    step(0, BASE, 16'h0003, 2'b01);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL irq_early: got %b want 0", interrupt);
    end
    step(0, 16'h0, 16'h0, 2'b00);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got %b want 1", interrupt);
    end
    step(BASE, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h000A) begin
      errors++; $display("FAIL irq_ctrl: got %h want 000a", dread_data);
    end
    step(0, BASE, 16'h0008, 2'b01);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL irq_drop: got %b want 0", interrupt);
    end
  endtask

  task automatic test_read();
    do_reset();
    step(0, BASE + 16'd6, 16'h1234, 2'b11);
    step(0, BASE + 16'd2, 16'h00AB, 2'b11);
    step(BASE + 16'd6, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h1234) begin
      errors++; $display("FAIL read_count: got %h want 1234", dread_data);
    end
    step(BASE + 16'd7, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h0012) begin
      errors++; $display("FAIL read_odd_edge: got %h want 0012", dread_data);
    end
    step(BASE + 16'd1, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'hAB00) begin
      errors++; $display("FAIL read_odd: got %h want ab00", dread_data);
    end
  endtask

  task automatic test_lanes();
    step(0, BASE + 16'd5, 16'hABCD, 2'b01);
    step(BASE + 16'd4, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'hCD00) begin
      errors++; $display("FAIL lane_reload_hi: got %h want cd00", dread_data);
    end
    step(0, BASE + 16'd7, 16'hFFFF, 2'b10);
    step(BASE + 16'd6, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h1234) begin
      errors++; $display("FAIL lane_outside: got %h want 1234", dread_data);
    end
    step(0, BASE - 16'd1, 16'h5A77, 2'b11);
    step(BASE, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h0002) begin
      errors++; $display("FAIL lane_partial: got %h want 0002", dread_data);
    end
  endtask

  task automatic test_collide();
    do_reset();
    step(0, BASE + 16'd6, 16'h0003, 2'b11);
    step(0, BASE, 16'h0001, 2'b01);
    step(0, 16'h0, 16'h0, 2'b00);
    step(0, BASE + 16'd6, 16'h00AA, 2'b11);
    step(BASE + 16'd6, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h00AA) begin
      errors++; $display("FAIL collide_count: got %h want 00aa", dread_data);
    end
    do_reset();
    step(0, BASE + 16'd4, 16'h0005, 2'b11);
    step(0, BASE, 16'h0005, 2'b01);
    for (int k = 0; k < 6; k++) step(0, 16'h0, 16'h0, 2'b00);
    step(0, BASE, 16'h000D, 2'b01);
    step(BASE, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h000D) begin
      errors++; $display("FAIL collide_flag: got %h want 000d", dread_data);
    end
    step(0, BASE, 16'h000D, 2'b01);
    step(BASE, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h0005) begin
      errors++; $display("FAIL flag_clear: got %h want 0005", dread_data);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    step(0, BASE + 16'd2, 16'h0003, 2'b11);
    step(0, BASE + 16'd6, 16'h0001, 2'b11);
    step(0, BASE, 16'h0003, 2'b01);
    step(BASE, 16'h0, 16'h0, 2'b00);
    checks++;
    if (dread_data !== 16'h0003) begin
      errors++; $display("FAIL midcount_running: got %h want 0003", dread_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dread_data !== 16'h0000 || interrupt !== 1'b0) begin
      errors++; $display("FAIL midcount_async: got %h/%b want 0000/0", dread_data, interrupt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      step(BASE, 16'h0, 16'h0, 2'b00);
      checks++;
      if (interrupt !== 1'b0 || dread_data !== 16'h0000) begin
        errors++; $display("FAIL midcount_after%0d: got %h/%b want 0000/0", k, dread_data, interrupt);
      end
    end
  endtask

`ifdef IO_TIMER_PWM_EN
  task automatic test_pwm();
    do_reset();
    step(0, BASE + 16'd2, 16'h0003, 2'b11);
    step(0, BASE + 16'd8, 16'h0004, 2'b11);
    step(0, BASE + 16'd6, 16'h0002, 2'b11);
    checks++;
    if (pwm !== 1'b0) begin
      errors++; $display("FAIL pwm_stopped: got %b want 0", pwm);
    end
    step(0, BASE, 16'h0001, 2'b01);
    checks++;
    if (pwm !== 1'b1) begin
      errors++; $display("FAIL pwm_high: got %b want 1", pwm);
    end
    step(0, BASE + 16'd6, 16'h0010, 2'b11);
    checks++;
    if (pwm !== 1'b0) begin
      errors++; $display("FAIL pwm_low: got %b want 0", pwm);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] ra, wa, wd;
    logic [1:0]  we;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ra = BASE - 16'd2 + 16'($urandom_range(0, 13));
      wa = BASE - 16'd2 + 16'($urandom_range(0, 13));
      we = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      wd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      step(ra, wa, wd, we);
      checks++;
      if (dread_data !== m_rdata) begin
        errors++; $display("FAIL rand_rdata @%0d: got %h want %h", i, dread_data, m_rdata);
      end
      checks++;
      if (interrupt !== m_irq) begin
        errors++; $display("FAIL rand_irq @%0d: got %b want %b", i, interrupt, m_irq);
      end
`ifdef IO_TIMER_PWM_EN
      checks++;
      if (pwm !== m_pwm) begin
        errors++; $display("FAIL rand_pwm @%0d: got %b want %b", i, pwm, m_pwm);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_autoreload();
    test_irq();
    test_read();
    test_lanes();
    test_collide();
    test_reset_midcount();
`ifdef IO_TIMER_PWM_EN
    test_pwm();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 SHALL have parameter BASEADDR, default 16'h0010, byte address of the register window.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on posedge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port dread_addr, input, 16 bits: read byte address, presented in cycle N.
REQ-005 SHALL have port dread_data, output, 16 bits: registered read data, valid in cycle N+1.
REQ-006 SHALL have port dwrite_addr, input, 16 bits: write byte address.
REQ-007 SHALL have port dwrite_data, input, 16 bits: write data, low byte in [7:0].
REQ-008 SHALL have port dwrite_en, input, 2 bits: bit0 writes byte at dwrite_addr, bit1 writes byte at dwrite_addr+1.
REQ-009 SHALL have port interrupt, output, 1 bit: level interrupt request.

Function
REQ-010 SHALL decode each byte lane independently; the window is little-endian 16-bit registers: +0 CTRL, +2 PRESCALE, +4 RELOAD, +6 COUNT.
REQ-011 CTRL bits SHALL be: [0] EN, [1] IE, [2] AUTORELOAD, [3] FLAG (write 1 clears, write 0 no effect); [15:4] read 0.
REQ-012 Reads SHALL return {byte(dread_addr+1), byte(dread_addr)} one cycle later; bytes outside the window read 8'h00; address arithmetic wraps at 16 bits.
REQ-013 Writes with any dwrite_en bit outside the window SHALL be ignored for that byte only.
REQ-014 Prescaler SHALL count 0..PRESCALE while EN=1, emitting a one-cycle tick on reaching PRESCALE and returning to 0; PRESCALE=0 ticks every cycle.
REQ-015 States SHALL be STOPPED (EN=0, prescaler held at 0) and RUNNING (EN=1).
REQ-016 On tick with COUNT!=0 SHALL decrement COUNT by 1.
REQ-017 On tick with COUNT==0 SHALL set FLAG; if AUTORELOAD=1 load COUNT<=RELOAD and stay RUNNING, else clear EN and go to STOPPED.
REQ-018 A bus write to COUNT SHALL take precedence over decrement/reload in the same cycle.
REQ-019 FLAG set by expiry SHALL win over a simultaneous write-1-clear.
REQ-020 Any write to a PRESCALE byte or to CTRL.EN SHALL reset the prescaler to 0.
REQ-021 interrupt SHALL equal FLAG AND IE, driven from flops, no combinational path from bus inputs.

Reset
REQ-022 On reset SHALL force: CTRL=0, PRESCALE=0, RELOAD=0, COUNT=0, prescaler=0, state STOPPED, dread_data=16'h0000, interrupt=0.
REQ-023 Reset asserted mid-count SHALL abort immediately; no FLAG is set on release.

Configuration
REQ-024 With IO_TIMER_PWM_EN defined SHALL add register COMPARE at +8 (window 10 bytes) and output port pwm (1 bit, registered) = EN AND (COUNT < COMPARE); COMPARE resets to 0.
REQ-025 Without IO_TIMER_PWM_EN SHALL omit pwm and COMPARE; window is 8 bytes and +8/+9 read 8'h00.

Structure
REQ-026 Package io_timer_pkg SHALL hold register offsets, CTRL bit indices, and the state enum.
REQ-027 Prescaler SHALL be sub-module io_timer_prescaler (inputs enable, clear, limit; output tick).

Verification
REQ-028 Write 16'h0003 to BASE+2 and 16'h0002 to BASE+6 via dwrite_en=2'b11, then 8'h05 (EN|AUTORELOAD) to BASE+0 -> FLAG sets on the third tick (12 cycles after EN), and COUNT loads RELOAD.
REQ-029 Write 8'h03 (EN|IE) with COUNT=0, PRESCALE=0 -> interrupt rises next tick, EN clears; write 8'h08 to CTRL -> interrupt drops next cycle.
REQ-030 dread_addr=BASE+6 in cycle N with COUNT=16'h1234 -> dread_data=16'h1234 in N+1; dread_addr=BASE+7 -> 16'h0012 (if no PWM) with high byte from +8.
REQ-031 dwrite_en=2'b01 to BASE+5 with data 16'hABCD -> only RELOAD[15:8]=8'hCD; dwrite_en=2'b10 at BASE+7 -> no register change.
REQ-032 Write to COUNT coinciding with a tick -> written value retained, no decrement; FLAG clear coinciding with expiry -> FLAG remains 1.
REQ-033 Assert reset while RUNNING with COUNT=16'h0001 -> all outputs 0 within same cycle, no interrupt after release; with IO_TIMER_PWM_EN, COMPARE=4, COUNT=2 -> pwm=1.
